// File: rtl/dp_ram_stream_reader.sv
// dp_ram_stream_reader: read-side controller for the dual-port line RAM.
// Issues sequential single-line reads over a (wrapping) address range,
// absorbs the RAM's 1-cycle read latency and presents the data as a
// valid/ready stream through a 2-entry skid buffer (head/tail).
module dp_ram_stream_reader #(
  parameter int NUMBER_OF_LINES = 8192,
  parameter int DATA_WIDTH      = 128,
  localparam int AW             = $clog2(NUMBER_OF_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW:0]           num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_r_en,
  output logic [AW-1:0]         ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_mem_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUMBER_OF_LINES - 1);
  localparam logic [AW:0]   MAX_LINES = (AW+1)'(NUMBER_OF_LINES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW:0]           remaining_q, remaining_d;
  logic [AW:0]           beats_left_q, beats_left_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            level;
  logic                  issue;
  logic [AW:0]           clamped_lines;

  // Handshake, capture and read-issue decisions from registered state.
  // The buffer level after this cycle's pop, plus any read in flight, must
  // leave room for one more beat before a new read may be issued.
  always_comb begin
    pop           = (occ_q != 2'd0) && out_ready;
    push          = inflight_q && ram_mem_valid;
    level         = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue         = (state_q == RUN) && (remaining_q != '0) && (level < 3'd2);
    clamped_lines = (num_lines > MAX_LINES) ? MAX_LINES : num_lines;
  end

  // Next-state logic for the command FSM, address/count tracking and the
  // two-entry skid buffer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    inflight_d   = issue;
    occ_d        = occ_q;
    head_d       = head_q;
    tail_d       = tail_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = start_addr;
          remaining_d  = clamped_lines;
          beats_left_d = clamped_lines;
          if (clamped_lines == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
          remaining_d = remaining_q - (AW+1)'(1);
        end
        if (pop) begin
          beats_left_d = beats_left_q - (AW+1)'(1);
          if (beats_left_q == (AW+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Head is always the oldest beat; the tail only holds a second beat
    // when the consumer stalls while a read is still returning.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = ram_rd_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = ram_rd_data;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = ram_rd_data;
        end else begin
          head_d = ram_rd_data;
        end
      end
      default: ;
    endcase
  end

  // State registers; asynchronous reset discards any command in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign ram_r_en   = issue;
  assign ram_addr_r = addr_q;
  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = head_q;
  assign out_last   = out_valid && (beats_left_q == (AW+1)'(1));

endmodule

// File: tb/tb_dp_ram_stream_reader.sv
// Testbench for dp_ram_stream_reader: RAM model with mem[k]=k and 1-cycle
// latency, a table of commands with out_ready patterns, and hand-written
// sequences for start-in-done-cycle and mid-transfer reset.
module tb_dp_ram_stream_reader;

  localparam int NL = 8192;
  localparam int DW = 128;
  localparam int AW = $clog2(NL);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   num_lines = '0;
  logic          busy;
  logic          done;
  logic          ram_r_en;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_rd_data = '0;
  logic          ram_mem_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sa;
    int          nl;
    logic [15:0] pat;
    int          exp_n;
    bit          timing;
    int          pulse_cyc;
  } vec_t;

  dp_ram_stream_reader #(
    .NUMBER_OF_LINES(NL),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_addr(start_addr),
    .num_lines(num_lines),
    .busy(busy),
    .done(done),
    .ram_r_en(ram_r_en),
    .ram_addr_r(ram_addr_r),
    .ram_rd_data(ram_rd_data),
    .ram_mem_valid(ram_mem_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Line RAM read port model: mem[k] = k, data and valid one cycle after r_en.
  always @(posedge clk) begin
    ram_mem_valid <= ram_r_en;
    ram_rd_data   <= DW'(ram_addr_r);
  end

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one command whose start is already driven for the cycle ending at
  // the next rising edge (edge 0). Cycle c is sampled at its falling edge.
  task automatic run_body(input string tag, input int sa, input int exp_n,
                          input logic [15:0] pat, input bit timing, input int pulse_cyc);
    int idx, issued, iss_addr, first_beat, last_cyc, done_cyc, first_issue, budget;
    logic [DW-1:0] prev_data;
    logic prev_stall, pop;
    idx = 0; issued = 0; iss_addr = sa; first_beat = -1; last_cyc = -1;
    done_cyc = -1; first_issue = -1; prev_stall = 1'b0; prev_data = '0;
    budget = 4 * exp_n + 40;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) begin
        start_addr = AW'(300);
        num_lines  = (AW+1)'(2);
      end
      out_ready = pat[cyc % 16];
      @(negedge clk);
      pop = out_valid && out_ready;
      if (ram_r_en) begin
        chk_i({tag, " raddr"}, int'(ram_addr_r), iss_addr);
        issued++;
        if (first_issue < 0) first_issue = cyc;
        iss_addr = (iss_addr + 1) % NL;
      end
      chk_i({tag, " window"}, int'((issued - idx - int'(pop)) <= 2), 1);
      if (prev_stall) begin
        chk_i({tag, " hold_valid"}, int'(out_valid), 1);
        chk_d({tag, " hold_data"}, out_data, prev_data);
      end
      if (out_valid) begin
        chk_d({tag, " data"}, out_data, DW'((sa + idx) % NL));
        chk_i({tag, " last"}, int'(out_last), int'(idx == exp_n - 1));
        if (first_beat < 0) first_beat = cyc;
      end else begin
        chk_i({tag, " last_idle"}, int'(out_last), 0);
      end
      if (done) begin
        done_cyc = cyc;
        chk_i({tag, " busy_at_done"}, int'(busy), 0);
      end else if (exp_n > 0) begin
        chk_i({tag, " busy"}, int'(busy), 1);
      end
      if (pop) begin
        if (idx == exp_n - 1) last_cyc = cyc;
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    if (done_cyc < 0) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: got no done expected done within %0d cycles", tag, budget);
    end
    chk_i({tag, " beats"}, idx, exp_n);
    chk_i({tag, " issues"}, issued, exp_n);
    if (exp_n == 0) chk_i({tag, " done_cyc"}, done_cyc, 1);
    else            chk_i({tag, " done_cyc"}, done_cyc, last_cyc + 1);
    if (timing && exp_n > 0) begin
      chk_i({tag, " first_issue"}, first_issue, 1);
      chk_i({tag, " first_beat"}, first_beat, 3);
      chk_i({tag, " last_cyc"}, last_cyc, exp_n + 2);
    end
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(v.sa);
    num_lines  = (AW+1)'(v.nl);
    out_ready  = v.pat[0];
    run_body(tag, v.sa, v.exp_n, v.pat, v.timing, v.pulse_cyc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_i({tag, " busy"}, int'(busy), 0);
    chk_i({tag, " done"}, int'(done), 0);
    chk_i({tag, " out_valid"}, int'(out_valid), 0);
    chk_i({tag, " out_last"}, int'(out_last), 0);
    chk_i({tag, " ram_r_en"}, int'(ram_r_en), 0);
    chk_i({tag, " ram_addr_r"}, int'(ram_addr_r), 0);
    chk_d({tag, " out_data"}, out_data, '0);
  endtask

  // Absolute time bound so the bench always terminates.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test expected completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{sa: 10,   nl: 4,    pat: 16'hFFFF, exp_n: 4,    timing: 1'b1, pulse_cyc: 0};
    vecs[1] = '{sa: 8190, nl: 4,    pat: 16'hFFFF, exp_n: 4,    timing: 1'b1, pulse_cyc: 0};
    vecs[2] = '{sa: 100,  nl: 6,    pat: 16'h4949, exp_n: 6,    timing: 1'b0, pulse_cyc: 0};
    vecs[3] = '{sa: 0,    nl: 0,    pat: 16'hFFFF, exp_n: 0,    timing: 1'b0, pulse_cyc: 0};
    vecs[4] = '{sa: 200,  nl: 5,    pat: 16'hFFFF, exp_n: 5,    timing: 1'b1, pulse_cyc: 2};
    vecs[5] = '{sa: 7000, nl: 3,    pat: 16'h0101, exp_n: 3,    timing: 1'b0, pulse_cyc: 0};
    vecs[6] = '{sa: 5,    nl: 8193, pat: 16'hFFFF, exp_n: 8192, timing: 1'b1, pulse_cyc: 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven commands
    foreach (vecs[i]) begin
      run_cmd($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: start driven in the cycle where done is high
    run_cmd("chain_a", '{sa: 40, nl: 2, pat: 16'hFFFF, exp_n: 2, timing: 1'b1, pulse_cyc: 0});
    chk_i("chain_a done_now", int'(done), 1);
    start      = 1'b1;
    start_addr = AW'(50);
    num_lines  = (AW+1)'(3);
    out_ready  = 1'b1;
    run_body("chain_b", 50, 3, 16'hFFFF, 1'b1, 0);

    // Mid-transfer reset with both buffer entries full
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(400);
    num_lines  = (AW+1)'(6);
    out_ready  = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk_i("stall out_valid", int'(out_valid), 1);
    chk_d("stall out_data", out_data, DW'(400));
    chk_i("stall full no_issue", int'(ram_r_en), 0);
    chk_i("stall busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_i("post_reset out_valid", int'(out_valid), 0);
      chk_i("post_reset done", int'(done), 0);
      chk_i("post_reset ram_r_en", int'(ram_r_en), 0);
    end

    // Recovery after reset
    run_cmd("recover", '{sa: 20, nl: 2, pat: 16'hFFFF, exp_n: 2, timing: 1'b1, pulse_cyc: 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
